bongo_poll_scheduler: RTL
=========================

Name: bongo_poll_scheduler

Overview:
- Sequences the single-wire bongo protocol engine so that it serves two bongo controllers (player 0, player 1), polling them alternately on a fixed slot period.
- Owns retries, the response timeout and per-player fault tracking.
- Holds the latest good sample for each player for the downstream translators.
- Sits between the protocol engine (bonk) and the per-player translator logic.

Parameters:
- POLL_PERIOD, 16500: clk cycles per poll slot. Minimum 4.
- TIMEOUT, 8000: clk cycles to wait for engine done/error after start. Must be less than POLL_PERIOD.
- MAX_RETRY, 2: re-issues allowed after a failed attempt, so at most MAX_RETRY+1 attempts per slot.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock, clk; rst_n is asynchronous, active-low.
- enable  in  1  global scheduler enable.
- port_en  in  2  per-player enable.
- eng_start  out  1  one-cycle start pulse to the protocol engine.
- eng_sel  out  1  player routed to the engine data port; stable for the whole transaction.
- eng_busy  in  1  engine busy.
- eng_done  in  1  one-cycle pulse: response valid on eng_hit/eng_scream.
- eng_err  in  1  one-cycle pulse: protocol/framing error.
- eng_hit  in  8  engine hit byte.
- eng_scream  in  12  engine microphone level.
- hit_q  out  16  latched hits: [7:0] player 0, [15:8] player 1.
- scream_q  out  24  latched scream: [11:0] player 0, [23:12] player 1.
- valid  out  2  per-player data valid.
- update  out  2  one-cycle pulse when that player's data is refreshed.
- fault  out  2  sticky per-player fault.
- overrun  out  1  sticky: a slot expired while a slot was already pending.

Behaviour:
- Reset: FSM=IDLE; every output 0; rr pointer=player 0; slot counter=0; pending=0; retry and timeout counters=0.
- Slot timer:
  - Free-runs while enable=1; cleared while enable=0.
  - On count POLL_PERIOD-1 it wraps to 0 and sets pending.
  - If pending is already set at that moment, the expiry is dropped and overrun is set.
- FSM states: IDLE, WAIT_SLOT, ISSUE, WAIT_RESP, COMMIT.
- IDLE -> WAIT_SLOT when enable=1.
- WAIT_SLOT:
  - If enable=0 -> IDLE.
  - If pending=1 and any port_en bit is set: pick the target player round-robin starting after the last served player, skipping disabled players. Latch eng_sel, clear pending, clear the retry counter, go to ISSUE.
  - If pending=1 and both port_en bits are 0: pending clears and no transaction starts.
- ISSUE:
  - Wait while eng_busy=1 (no timeout in this state).
  - When eng_busy=0: assert eng_start for exactly 1 cycle, clear the timeout counter, go to WAIT_RESP.
- WAIT_RESP:
  - eng_done without eng_err -> COMMIT.
  - eng_err, or timeout counter reaching TIMEOUT-1: if retry < MAX_RETRY, increment retry and go to ISSUE.
  - Otherwise (retries exhausted): set fault[sel], clear valid[sel], zero that player's hit/scream fields, go to WAIT_SLOT.
  - eng_done and eng_err in the same cycle counts as an error.
- COMMIT:
  - Capture the engine data into the selected player's fields, set valid[sel], pulse update[sel] for 1 cycle, clear fault[sel].
  - Go to WAIT_SLOT, or IDLE if enable=0.
  - Latency: eng_done at cycle t gives hit_q/valid/update at t+1.
- Engine pulses: eng_done/eng_err outside WAIT_RESP are ignored.
- enable deasserted mid-transaction: the current transaction completes (including retries), then the FSM goes to IDLE. No new slot starts.
- port_en[i] deasserted: on the next cycle valid[i]=0 and player i's fields are zeroed. fault[i] is held. A transaction already in flight for player i completes but does not commit.
- Fault recovery: fault[i] stays set until a successful commit for player i or reset.
- overrun is cleared only by reset.
- Asynchronous reset mid-transaction returns every register to its reset value immediately. eng_start must not glitch.

Decomposition:
- Package bongo_pkg:
  - state enum (IDLE, WAIT_SLOT, ISSUE, WAIT_RESP, COMMIT);
  - NUM_PLAYERS=2, HIT_W=8, SCREAM_W=12;
  - field-offset constants for the packed outputs.
- One sub-module, poll_slot_timer: POLL_PERIOD counter with pending/overrun flag logic and consume input.

Test Plan (bench parameters POLL_PERIOD=100, TIMEOUT=40, MAX_RETRY=2):
- Alternation: both ports enabled, engine answers done 10 cycles after start with hit=8'h15 / 8'h02 -> eng_sel alternates 0,1,0; hit_q=16'h0215; update pulses 1 cycle each; valid=2'b11.
- Error then retry: player 0 engine gives eng_err, then done with hit=8'h08 -> exactly 2 eng_start pulses, hit_q[7:0]=8'h08, fault[0]=0.
- Timeout exhaustion: engine silent for player 1 -> 3 starts spaced 40+1 cycles apart, then fault[1]=1, valid[1]=0, hit_q[15:8]=0. The next good poll clears fault[1].
- Skip disabled: port_en=2'b01 -> every slot selects player 0. Clearing port_en[0] mid-WAIT_RESP -> valid[0]=0 next cycle; the later done produces no update.
- Busy stall and overrun: hold eng_busy=1 for 250 cycles -> no eng_start while busy, overrun=1. After busy drops, exactly 1 start occurs.
- Reset: assert rst_n=0 during WAIT_RESP -> all outputs 0 immediately. After release, the first start follows the first slot expiry at cycle 100.

Source files
------------

// File: rtl/bongo_pkg.sv
// Shared types and field layout for the bongo poll scheduler.
// Player p owns bits [p*W +: W] of each packed output.
package bongo_pkg;

  localparam int NUM_PLAYERS = 2;
  localparam int HIT_W       = 8;
  localparam int SCREAM_W    = 12;

  localparam int HIT_LSB_P0    = 0;
  localparam int HIT_LSB_P1    = HIT_W;
  localparam int SCREAM_LSB_P0 = 0;
  localparam int SCREAM_LSB_P1 = SCREAM_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    ISSUE     = 3'd2,
    WAIT_RESP = 3'd3,
    COMMIT    = 3'd4
  } state_e;

  // ptr is the next player in line; fall back to the other one when ptr is disabled.
  function automatic logic rr_pick(input logic ptr, input logic [NUM_PLAYERS-1:0] en);
    return en[ptr] ? ptr : ~ptr;
  endfunction

endpackage

// File: rtl/bongo_poll_scheduler_poll_slot_timer.sv
// Poll slot timer: free-running period counter that raises a pending slot flag
// and records an overrun when a slot expires while the previous one is still unclaimed.
module poll_slot_timer #(
  parameter int POLL_PERIOD = 16500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic consume_i,
  output logic pending_o,
  output logic overrun_o
);

  localparam int CW = $clog2(POLL_PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          expire;

  assign expire = enable_i && (cnt_q == CW'(POLL_PERIOD - 1));

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (!enable_i) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      cnt_d = expire ? '0 : cnt_q + 1'b1;
      if (consume_i) pending_d = 1'b0;
      // A claim in the same cycle frees the flag, so that expiry is kept, not dropped.
      if (expire) begin
        if (pending_q && !consume_i) overrun_d = 1'b1;
        else                         pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/bongo_poll_scheduler.sv
// Two-player bongo poll scheduler: alternates engine transactions per slot,
// retries failures, tracks faults and holds the last good sample per player.
module bongo_poll_scheduler
  import bongo_pkg::*;
#(
  parameter int POLL_PERIOD = 16500,
  parameter int TIMEOUT     = 8000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [NUM_PLAYERS-1:0]           port_en,
  output logic                             eng_start,
  output logic                             eng_sel,
  input  logic                             eng_busy,
  input  logic                             eng_done,
  input  logic                             eng_err,
  input  logic [HIT_W-1:0]                 eng_hit,
  input  logic [SCREAM_W-1:0]              eng_scream,
  output logic [NUM_PLAYERS*HIT_W-1:0]     hit_q,
  output logic [NUM_PLAYERS*SCREAM_W-1:0]  scream_q,
  output logic [NUM_PLAYERS-1:0]           valid,
  output logic [NUM_PLAYERS-1:0]           update,
  output logic [NUM_PLAYERS-1:0]           fault,
  output logic                             overrun,
  output logic [2:0]                       dbg_state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   rr_q, rr_d;
  logic                   start_q, start_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [HIT_W-1:0]       hit_pl_q [NUM_PLAYERS];
  logic [HIT_W-1:0]       hit_pl_d [NUM_PLAYERS];
  logic [SCREAM_W-1:0]    scr_pl_q [NUM_PLAYERS];
  logic [SCREAM_W-1:0]    scr_pl_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] valid_q, valid_d;
  logic [NUM_PLAYERS-1:0] update_q, update_d;
  logic [NUM_PLAYERS-1:0] fault_q, fault_d;
  logic                   pending, consume, pick;

  poll_slot_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable),
    .consume_i (consume),
    .pending_o (pending),
    .overrun_o (overrun)
  );

  assign pick = rr_pick(rr_q, port_en);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    start_d  = 1'b0;
    retry_d  = retry_q;
    tcnt_d   = tcnt_q;
    hit_pl_d = hit_pl_q;
    scr_pl_d = scr_pl_q;
    valid_d  = valid_q;
    update_d = '0;
    fault_d  = fault_q;
    consume  = 1'b0;

    case (state_q)
      IDLE: if (enable) state_d = WAIT_SLOT;
      WAIT_SLOT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (pending) begin
          consume = 1'b1;
          if (|port_en) begin
            sel_d   = pick;
            rr_d    = ~pick;
            retry_d = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!eng_busy) begin
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        tcnt_d = tcnt_q + 1'b1;
        // Error wins over a coincident done.
        if (eng_err || tcnt_q == TW'(TIMEOUT - 1)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ISSUE;
          end else begin
            fault_d[sel_q]  = 1'b1;
            valid_d[sel_q]  = 1'b0;
            hit_pl_d[sel_q] = '0;
            scr_pl_d[sel_q] = '0;
            state_d         = WAIT_SLOT;
          end
        end else if (eng_done) begin
          // Capture here so the sample lands one cycle after done.
          if (port_en[sel_q]) begin
            hit_pl_d[sel_q] = eng_hit;
            scr_pl_d[sel_q] = eng_scream;
            valid_d[sel_q]  = 1'b1;
            update_d[sel_q] = 1'b1;
            fault_d[sel_q]  = 1'b0;
          end
          state_d = COMMIT;
        end
      end
      COMMIT: state_d = enable ? WAIT_SLOT : IDLE;
      default: state_d = IDLE;
    endcase

    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (!port_en[p]) begin
        valid_d[p]  = 1'b0;
        update_d[p] = 1'b0;
        hit_pl_d[p] = '0;
        scr_pl_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      rr_q     <= 1'b0;
      start_q  <= 1'b0;
      retry_q  <= '0;
      tcnt_q   <= '0;
      valid_q  <= '0;
      update_q <= '0;
      fault_q  <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        hit_pl_q[p] <= '0;
        scr_pl_q[p] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      start_q  <= start_d;
      retry_q  <= retry_d;
      tcnt_q   <= tcnt_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      fault_q  <= fault_d;
      hit_pl_q <= hit_pl_d;
      scr_pl_q <= scr_pl_d;
    end
  end

  assign eng_start = start_q;
  assign eng_sel   = sel_q;
  assign valid     = valid_q;
  assign update    = update_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

  assign hit_q[HIT_LSB_P0 +: HIT_W]          = hit_pl_q[0];
  assign hit_q[HIT_LSB_P1 +: HIT_W]          = hit_pl_q[1];
  assign scream_q[SCREAM_LSB_P0 +: SCREAM_W] = scr_pl_q[0];
  assign scream_q[SCREAM_LSB_P1 +: SCREAM_W] = scr_pl_q[1];

endmodule
